// File: rtl/master_biu_pkg.sv
// master_biu_pkg: shared types and constants for the master bus interface unit.
//   state_e     FSM states (IDLE, REQ, XFER, DONE)
//   size_e      request/bus transfer size codes
//   CTRL_*      bit positions inside the 9-bit bus Control word
//   size_incr   byte increment applied to Address per completed beat
//   ctrl_word   assembles a Control word from its fields
package master_biu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  localparam int unsigned CTRL_W      = 9;
  localparam int unsigned CTRL_VALID  = 8;
  localparam int unsigned CTRL_BUSY   = 7;
  localparam int unsigned CTRL_WRITE  = 6;
  localparam int unsigned CTRL_SIZE_LO = 4;
  localparam int unsigned CTRL_LEN_LO = 0;
  localparam int unsigned CTRL_LEN_W  = 4;

  function automatic logic [31:0] size_incr(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

  function automatic logic [CTRL_W-1:0] ctrl_word(input logic busy, input logic write,
                                                  input logic [1:0] size,
                                                  input logic [CTRL_LEN_W-1:0] len);
    logic [CTRL_W-1:0] c;
    c = '0;
    c[CTRL_VALID]                    = 1'b1;
    c[CTRL_BUSY]                     = busy;
    c[CTRL_WRITE]                    = write;
    c[CTRL_SIZE_LO +: 2]             = size;
    c[CTRL_LEN_LO +: CTRL_LEN_W]     = len;
    return c;
  endfunction

endpackage

// File: rtl/master_biu_beat_ctr.sv
// master_biu_beat_ctr: per-transaction beat counter and address incrementer.
//   clk, reset   clock / synchronous active-high reset
//   load         latch start address, size and length; clear beat count
//   load_addr    start byte address
//   load_size    transfer size code (selects the address increment)
//   load_len     beats minus 1
//   step         one beat completed: advance address and count
//   addr         current beat address (wraps modulo 2^32)
//   last         current beat is the final one of the burst
module master_biu_beat_ctr
  import master_biu_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [31:0]      load_addr,
  input  logic [1:0]       load_size,
  input  logic [LEN_W-1:0] load_len,
  input  logic             step,
  output logic [31:0]      addr,
  output logic             last
);

  logic [1:0]       size_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= '0;
      size_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
    end else if (load) begin
      addr   <= load_addr;
      size_q <= load_size;
      len_q  <= load_len;
      cnt    <= '0;
    end else if (step) begin
      addr <= addr + size_incr(size_q);
      cnt  <= cnt + 1'b1;
    end
  end

  assign last = (cnt == len_q);

endmodule

// File: rtl/master_biu.sv
// master_biu: master-side bus interface unit feeding the SDRAM slave BIU.
// Accepts single/burst read/write requests, drives Address/DataIn/Control/en,
// paces beats on Ready and returns read data plus done/err status.
//   Requester side: req_valid/req_ready/req_write/req_addr/req_size/req_len,
//                   wr_data/wr_ready, rd_data/rd_valid, done/err
//   Bus side:       Address, DataIn, Control[8:0], en (out); DataOut, Ready (in)
//   Control = {valid, busy, write, size[1:0], len[3:0]}
// Optional build macro MASTER_BIU_TIMEOUT_EN: aborts XFER with err after
// TIMEOUT_CYCLES consecutive cycles without Ready (parameter exists only then).
module master_biu
  import master_biu_pkg::*;
#(
`ifdef MASTER_BIU_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 64,
`endif
  parameter int unsigned MAX_LEN_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [1:0]              req_size,
  input  logic [MAX_LEN_LOG2-1:0] req_len,
  input  logic [31:0]             wr_data,
  output logic                    wr_ready,
  output logic [31:0]             rd_data,
  output logic                    rd_valid,
  output logic                    done,
  output logic                    err,
  output logic [31:0]             Address,
  output logic [31:0]             DataIn,
  output logic [CTRL_W-1:0]       Control,
  output logic                    en,
  input  logic [31:0]             DataOut,
  input  logic                    Ready
);

  state_e      state;
  logic        wr_q;
  logic        accept;
  logic        beat_step;
  logic        beat_last;
  logic [31:0] beat_addr;
  logic        tmo_hit;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign beat_step = (state == ST_XFER) && Ready;

  master_biu_beat_ctr #(
    .LEN_W (MAX_LEN_LOG2)
  ) u_beat_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_addr (req_addr),
    .load_size (req_size),
    .load_len  (req_len),
    .step      (beat_step),
    .addr      (beat_addr),
    .last      (beat_last)
  );

`ifdef MASTER_BIU_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counts consecutive Ready-low XFER cycles; zero on XFER entry and on Ready.
  always_ff @(posedge clk) begin
    if (reset || (state != ST_XFER) || Ready) tmo_cnt <= '0;
    else                                      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == ST_XFER) && !Ready &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Write data passes straight through so a beat presented right after
  // wr_ready is on the bus in the same cycle, allowing Ready every cycle.
  assign DataIn   = (en && wr_q) ? wr_data : '0;
  assign Address  = en ? beat_addr : '0;
  assign wr_ready = beat_step && wr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      en        <= 1'b0;
      Control   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      wr_q      <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            wr_q      <= req_write;
            if (req_size == SIZE_ILLEGAL) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state   <= ST_REQ;
              en      <= 1'b1;
              Control <= ctrl_word(1'b0, req_write, req_size, CTRL_LEN_W'(req_len));
            end
          end
        end
        ST_REQ: begin
          state              <= ST_XFER;
          Control[CTRL_BUSY] <= 1'b1;
        end
        ST_XFER: begin
          if (Ready) begin
            if (!wr_q) begin
              rd_valid <= 1'b1;
              rd_data  <= DataOut;
            end
            if (beat_last) begin
              state   <= ST_DONE;
              en      <= 1'b0;
              Control <= '0;
              done    <= 1'b1;
            end
          end else if (tmo_hit) begin
            state   <= ST_DONE;
            en      <= 1'b0;
            Control <= '0;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_biu.sv
// tb_master_biu: randomized and directed stimulus for master_biu. Each
// transaction's expected per-cycle output trace is derived from the
// transaction-level rules (address = start + beat*bytes, read data one cycle
// after its Ready, done after the last Ready) and compared every cycle.
module tb_master_biu;

`ifdef MASTER_BIU_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [3:0]  req_len;
  logic [31:0] wr_data, rd_data, Address, DataIn, DataOut;
  logic        wr_ready, rd_valid, done, err, en, Ready;
  logic [8:0]  Control;

  always #5 clk = ~clk;

  master_biu #(
`ifdef MASTER_BIU_TIMEOUT_EN
    .TIMEOUT_CYCLES (TMO),
`endif
    .MAX_LEN_LOG2   (4)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_len(req_len),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .Address(Address), .DataIn(DataIn), .Control(Control),
    .en(en), .DataOut(DataOut), .Ready(Ready)
  );

  typedef struct {
    logic        rr, en, wrr, rdv, done, err;
    logic [8:0]  ctrl;
    logic [31:0] addr, din, rdd;
  } exp_t;

  exp_t expq[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [8:0]  lg_ctrl[$];
  logic [31:0] lg_addr[$], lg_rdd[$];
  logic        lg_rdv[$], lg_done[$], lg_err[$], lg_en[$], lg_rr[$], lg_wrr[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("req_ready", 32'(req_ready), 32'(e.rr));
      chk("en",        32'(en),        32'(e.en));
      chk("Control",   32'(Control),   32'(e.ctrl));
      chk("Address",   Address,        e.addr);
      chk("DataIn",    DataIn,         e.din);
      chk("wr_ready",  32'(wr_ready),  32'(e.wrr));
      chk("rd_valid",  32'(rd_valid),  32'(e.rdv));
      chk("done",      32'(done),      32'(e.done));
      chk("err",       32'(err),       32'(e.err));
      if (e.rdv) chk("rd_data", rd_data, e.rdd);
    end
  end

  function automatic exp_t zero_exp();
    exp_t e;
    e.rr = 1'b0; e.en = 1'b0; e.wrr = 1'b0; e.rdv = 1'b0; e.done = 1'b0; e.err = 1'b0;
    e.ctrl = '0; e.addr = '0; e.din = '0; e.rdd = '0;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = zero_exp();
    e.rr = 1'b1;
    return e;
  endfunction

  task automatic clear_logs();
    lg_ctrl.delete(); lg_addr.delete(); lg_rdd.delete(); lg_rdv.delete();
    lg_done.delete(); lg_err.delete(); lg_en.delete(); lg_rr.delete(); lg_wrr.delete();
  endtask

  task automatic tick(input exp_t e);
    expq.push_back(e);
    @(negedge clk);
    lg_ctrl.push_back(Control); lg_addr.push_back(Address); lg_rdd.push_back(rd_data);
    lg_rdv.push_back(rd_valid); lg_done.push_back(done); lg_err.push_back(err);
    lg_en.push_back(en); lg_rr.push_back(req_ready); lg_wrr.push_back(wr_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bus();
    wr_data = $urandom;
    Ready   = 1'($urandom_range(1, 0));
    DataOut = $urandom;
  endtask

  task automatic rand_req_fields();
    req_write = 1'($urandom_range(1, 0));
    req_addr  = $urandom;
    req_size  = 2'($urandom_range(3, 0));
    req_len   = 4'($urandom_range(15, 0));
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      req_valid = 1'b0;
      rand_req_fields();
      rand_bus();
      tick(idle_exp());
    end
  endtask

  function automatic exp_t xfer_exp(input logic w, input logic [31:0] a, input logic [1:0] sz,
                                    input logic [3:0] ln, input int b);
    exp_t e;
    e = zero_exp();
    e.en   = 1'b1;
    e.ctrl = {1'b1, 1'b1, w, sz, ln};
    e.addr = a + 32'(b) * (32'd1 << sz);
    e.din  = w ? wr_data : '0;
    return e;
  endfunction

  // One transaction: accept, REQ, XFER beats with gmin..gmax idle cycles before
  // each Ready, DONE. abort_beat >= 0 pulses reset at that beat instead.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic [3:0] ln, input int unsigned gmin, input int unsigned gmax,
                         input int abort_beat, input logic usefix, input logic [31:0] dfix);
    exp_t e;
    logic pv, nv;
    logic [31:0] pd, nd;
    int unsigned g;
    clear_logs();
    reset = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz; req_len = ln;
    rand_bus();
    tick(idle_exp());
    req_valid = 1'b0;
    rand_req_fields();
    if (sz == 2'b11) begin
      rand_bus();
      e = zero_exp(); e.done = 1'b1; e.err = 1'b1;
      tick(e);
      return;
    end
    rand_bus();
    e = zero_exp();
    e.en = 1'b1; e.ctrl = {1'b1, 1'b0, w, sz, ln}; e.addr = a; e.din = w ? wr_data : '0;
    tick(e);
    pv = 1'b0; pd = '0;
    for (int b = 0; b <= int'(ln); b++) begin
      g = $urandom_range(gmax, gmin);
      for (int unsigned k = 0; k <= g; k++) begin
        rand_bus();
        if (usefix) DataOut = dfix;
        if (b == abort_beat) begin
          reset = 1'b1; Ready = 1'b0;
          e = xfer_exp(w, a, sz, ln, b); e.rdv = pv; e.rdd = pd;
          tick(e);
          reset = 1'b0;
          rand_bus();
          tick(idle_exp());
          return;
        end
        Ready = (k == g);
        e = xfer_exp(w, a, sz, ln, b);
        e.wrr = w && Ready; e.rdv = pv; e.rdd = pd;
        nv = Ready && !w; nd = DataOut;
        tick(e);
        pv = nv; pd = nd;
      end
    end
    rand_bus();
    e = zero_exp(); e.done = 1'b1; e.rdv = pv; e.rdd = pd;
    tick(e);
  endtask

  task automatic stall_test();
    exp_t e;
    clear_logs();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_size = 2'b10; req_len = 4'd0;
    rand_bus();
    tick(idle_exp());
    req_valid = 1'b0;
    rand_bus();
    e = zero_exp(); e.en = 1'b1; e.ctrl = 9'h120; e.addr = 32'h40;
    tick(e);
`ifdef MASTER_BIU_TIMEOUT_EN
    for (int unsigned i = 0; i < TMO; i++) begin
      rand_bus(); Ready = 1'b0;
      tick(xfer_exp(1'b0, 32'h40, 2'b10, 4'd0, 0));
    end
    rand_bus();
    e = zero_exp(); e.done = 1'b1; e.err = 1'b1;
    tick(e);
    chk("tmo_en_last_xfer", 32'(lg_en[1 + TMO]), 32'd1);
    chk("tmo_done", 32'(lg_done[2 + TMO]), 32'd1);
    chk("tmo_err",  32'(lg_err[2 + TMO]),  32'd1);
`else
    for (int unsigned i = 0; i < 100; i++) begin
      rand_bus(); Ready = 1'b0;
      tick(xfer_exp(1'b0, 32'h40, 2'b10, 4'd0, 0));
    end
    chk("stall_en_100",   32'(lg_en[101]),   32'd1);
    chk("stall_ctrl_100", 32'(lg_ctrl[101]), 32'h1A0);
    reset = 1'b1; rand_bus(); Ready = 1'b0;
    tick(xfer_exp(1'b0, 32'h40, 2'b10, 4'd0, 0));
    reset = 1'b0; rand_bus();
    tick(idle_exp());
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt;
    reset = 1'b1; req_valid = 1'b0;
    rand_req_fields();
    rand_bus();
    @(posedge clk); #1;
    tick(idle_exp());
    chk("reset_req_ready", 32'(lg_rr[0]), 32'd1);
    chk("reset_ctrl", 32'(lg_ctrl[0]), 32'd0);
    reset = 1'b0;
    idle_cycles(2);

    // Single word read, Ready on the third XFER cycle.
    run_txn(1'b0, 32'h0000_0100, 2'b10, 4'd0, 2, 2, -1, 1'b1, 32'hDEAD_BEEF);
    chk("t1_ctrl_req",  32'(lg_ctrl[1]), 32'h120);
    chk("t1_ctrl_xfer", 32'(lg_ctrl[2]), 32'h1A0);
    chk("t1_rd_data",   lg_rdd[5], 32'hDEAD_BEEF);
    chk("t1_done",      32'(lg_done[5]), 32'd1);
    chk("t1_err",       32'(lg_err[5]), 32'd0);
    cnt = 0;
    foreach (lg_rdv[i]) cnt += 32'(lg_rdv[i]);
    chk("t1_rd_valid_count", cnt, 32'd1);

    // Word write burst of 4, Ready every cycle; back-to-back next request.
    run_txn(1'b1, 32'h0000_0200, 2'b10, 4'd3, 0, 0, -1, 1'b0, '0);
    chk("t2_addr0", lg_addr[2], 32'h200);
    chk("t2_addr1", lg_addr[3], 32'h204);
    chk("t2_addr2", lg_addr[4], 32'h208);
    chk("t2_addr3", lg_addr[5], 32'h20C);
    cnt = 0;
    foreach (lg_wrr[i]) cnt += 32'(lg_wrr[i]);
    chk("t2_wr_ready_count", cnt, 32'd4);

    // Half-word read burst wrapping past the top of the address space.
    run_txn(1'b0, 32'hFFFF_FFFE, 2'b01, 4'd1, 0, 0, -1, 1'b0, '0);
    chk("t3_addr0", lg_addr[2], 32'hFFFF_FFFE);
    chk("t3_addr1_wrap", lg_addr[3], 32'h0000_0000);

    // Illegal size: done+err next cycle, no bus activity.
    run_txn(1'b1, 32'h0000_0300, 2'b11, 4'd5, 0, 0, -1, 1'b0, '0);
    chk("t4_done", 32'(lg_done[1]), 32'd1);
    chk("t4_err",  32'(lg_err[1]),  32'd1);
    cnt = 0;
    foreach (lg_en[i]) cnt += 32'(lg_en[i]);
    chk("t4_en_never", cnt, 32'd0);
    idle_cycles(1);

    // Reset during beat 2 of a write burst.
    run_txn(1'b1, 32'h0000_0400, 2'b10, 4'd3, 0, 0, 2, 1'b0, '0);
    chk("t5_en_after_reset",   32'(lg_en[5]),   32'd0);
    chk("t5_ctrl_after_reset", 32'(lg_ctrl[5]), 32'd0);
    chk("t5_rr_after_reset",   32'(lg_rr[5]),   32'd1);
    chk("t5_no_done",          32'(lg_done[5]), 32'd0);
    idle_cycles(3);

    stall_test();
    idle_cycles(1);

    for (int unsigned t = 0; t < 60; t++) begin
      logic [1:0] sz;
      sz = ($urandom_range(7, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
      run_txn(1'($urandom_range(1, 0)), $urandom, sz, 4'($urandom_range(15, 0)),
              0, 3, -1, 1'b0, '0);
      idle_cycles($urandom_range(2, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
